// File: rtl/fir_pkg.sv
// Shared types, defaults and arithmetic helpers for the multi-channel decimating FIR.
package fir_pkg;

    typedef enum logic [1:0] {
        S_LOAD,
        S_MAC,
        S_WRITE
    } state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_TAPS       = 32;
    localparam int DEF_DECIMATION = 8;
    localparam int DEF_CHANNELS   = 2;
    localparam int DEF_FRAC_BITS  = 10;

    // Wide enough for the full product of any lane up to 64-bit samples.
    localparam int PROD_MAX = 128;

    function automatic logic signed [PROD_MAX-1:0] dequant(
        input logic signed [PROD_MAX-1:0] prod,
        input int unsigned                frac_bits
    );
        return prod >>> frac_bits;
    endfunction

    // Symmetric FM audio L+R low-pass, Q.10; h[0] in the most significant word.
    localparam logic [DEF_TAPS*DEF_DATA_WIDTH-1:0] FM_LPR_COEFF = {
        -32'sd3,   -32'sd2,   -32'sd2,   -32'sd3,
        -32'sd4,   -32'sd6,   -32'sd9,   -32'sd13,
        32'sd21,   32'sd250,  32'sd360,  32'sd465,
        32'sd540,  32'sd565,  32'sd578,  32'sd579,
        32'sd579,  32'sd578,  32'sd565,  32'sd540,
        32'sd465,  32'sd360,  32'sd250,  32'sd21,
        -32'sd13,  -32'sd9,   -32'sd6,   -32'sd4,
        -32'sd3,   -32'sd2,   -32'sd2,   -32'sd3
    };

endpackage

// File: rtl/fir_decim_mc_lane.sv
// One channel: sample history, MAC accumulator and output register.
module fir_mac_lane
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TAPS       = DEF_TAPS,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter logic [TAPS*DATA_WIDTH-1:0] COEFF = FM_LPR_COEFF,
    parameter int TCNT_W     = $clog2(TAPS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] x,
    input  logic                  acc_clr,
    input  logic                  mac_en,
    input  logic [TCNT_W-1:0]     tcnt,
    input  logic                  y_load_acc,
    input  logic                  y_load_x,
    output logic [DATA_WIDTH-1:0] y
);

    logic signed [DATA_WIDTH-1:0]   hist [TAPS];
    logic signed [DATA_WIDTH-1:0]   acc;
    logic signed [DATA_WIDTH-1:0]   coef;
    logic signed [DATA_WIDTH-1:0]   hsel;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [DATA_WIDTH-1:0]   term;
    logic signed [DATA_WIDTH-1:0]   acc_nxt;

    always_comb begin
        coef    = COEFF[(TAPS-1-int'(tcnt))*DATA_WIDTH +: DATA_WIDTH];
        hsel    = hist[tcnt];
        prod    = coef * hsel;
        term    = DATA_WIDTH'(dequant(PROD_MAX'(prod), FRAC_BITS));
        acc_nxt = acc + term;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                hist[i] <= '0;
            end
            acc <= '0;
            y   <= '0;
        end else begin
            if (shift_en) begin
                hist[0] <= x;
                for (int i = 1; i < TAPS; i++) begin
                    hist[i] <= hist[i-1];
                end
            end
            if (acc_clr) begin
                acc <= '0;
            end else if (mac_en) begin
                acc <= acc_nxt;
            end
            // Bypass captures the sample being shifted in this very cycle.
            if (y_load_x) begin
                y <= x;
            end else if (y_load_acc) begin
                y <= acc_nxt;
            end
        end
    end

endmodule

// File: rtl/fir_decim_mc.sv
// Time-multiplexed decimating FIR: shared FSM and counters driving CHANNELS MAC lanes.
module fir_decim_mc
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TAPS       = DEF_TAPS,
    parameter int DECIMATION = DEF_DECIMATION,
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter logic [TAPS*DATA_WIDTH-1:0] COEFF = FM_LPR_COEFF
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CHANNELS*DATA_WIDTH-1:0] x_in,
    input  logic                           x_in_empty,
    output logic                           x_in_rd_en,
    input  logic                           bypass,
    output logic [CHANNELS*DATA_WIDTH-1:0] y_out,
    input  logic                           y_out_full,
    output logic                           y_out_wr_en
);

    localparam int TCNT_W = $clog2(TAPS);
    localparam int DCNT_W = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;

    state_t            state;
    logic [DCNT_W-1:0] dcnt;
    logic [TCNT_W-1:0] tcnt;

    logic frame_done;
    logic last_tap;
    logic mac_en;
    logic acc_clr;
    logic y_load_x;
    logic y_load_acc;

    assign x_in_rd_en  = !reset && (state == S_LOAD) && !x_in_empty;
    assign y_out_wr_en = !reset && (state == S_WRITE) && !y_out_full;

    assign frame_done = (dcnt == DCNT_W'(DECIMATION - 1));
    assign last_tap   = (tcnt == TCNT_W'(TAPS - 1));
    assign mac_en     = (state == S_MAC);
    assign acc_clr    = x_in_rd_en && frame_done && !bypass;
    assign y_load_x   = x_in_rd_en && frame_done && bypass;
    assign y_load_acc = mac_en && last_tap;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_LOAD;
            dcnt  <= '0;
            tcnt  <= '0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    if (x_in_rd_en) begin
                        if (frame_done) begin
                            dcnt <= '0;
                            if (bypass) begin
                                state <= S_WRITE;
                            end else begin
                                state <= S_MAC;
                                tcnt  <= '0;
                            end
                        end else begin
                            dcnt <= dcnt + DCNT_W'(1);
                        end
                    end
                end
                S_MAC: begin
                    tcnt <= tcnt + TCNT_W'(1);
                    if (last_tap) begin
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (y_out_wr_en) begin
                        state <= S_LOAD;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        fir_mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .TAPS       (TAPS),
            .FRAC_BITS  (FRAC_BITS),
            .COEFF      (COEFF),
            .TCNT_W     (TCNT_W)
        ) u_lane (
            .clock      (clock),
            .reset      (reset),
            .shift_en   (x_in_rd_en),
            .x          (x_in[c*DATA_WIDTH +: DATA_WIDTH]),
            .acc_clr    (acc_clr),
            .mac_en     (mac_en),
            .tcnt       (tcnt),
            .y_load_acc (y_load_acc),
            .y_load_x   (y_load_x),
            .y          (y_out[c*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_fir_decim_mc.sv
// Directed bench for fir_decim_mc with the default FM audio coefficient set.
module tb_fir_decim_mc;

    localparam int DW   = 32;
    localparam int CH   = 2;
    localparam int TAPS = 32;
    localparam int DEC  = 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic               reset;
    logic [CH*DW-1:0]   x_in;
    logic               x_in_empty;
    logic               x_in_rd_en;
    logic               bypass;
    logic [CH*DW-1:0]   y_out;
    logic               y_out_full;
    logic               y_out_wr_en;

    fir_decim_mc dut (
        .clock       (clock),
        .reset       (reset),
        .x_in        (x_in),
        .x_in_empty  (x_in_empty),
        .x_in_rd_en  (x_in_rd_en),
        .bypass      (bypass),
        .y_out       (y_out),
        .y_out_full  (y_out_full),
        .y_out_wr_en (y_out_wr_en)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [DW-1:0] src0 [$];
    logic signed [DW-1:0] src1 [$];
    logic signed [DW-1:0] got0 [$];
    logic signed [DW-1:0] got1 [$];
    int rd_cyc [$];
    int wr_cyc [$];

    task automatic do_reset();
        @(negedge clock);
        reset      = 1'b1;
        x_in_empty = 1'b1;
        y_out_full = 1'b0;
        bypass     = 1'b0;
        x_in       = '0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic load_impulse(input int n);
        src0.delete();
        src1.delete();
        for (int i = 0; i < n; i++) begin
            src0.push_back((i == 0) ? 32'sd1024 : 32'sd0);
            src1.push_back(32'sd0);
        end
    endtask

    // FWFT source and sink model; stops once n_out writes have been seen.
    task automatic run(input int n_out, input bit starve, input int budget);
        int idx = 0;
        int cyc = 0;
        got0.delete();
        got1.delete();
        rd_cyc.delete();
        wr_cyc.delete();
        while (got0.size() < n_out && cyc < budget) begin
            @(negedge clock);
            x_in_empty = (idx >= src0.size()) || (starve && $urandom_range(0, 2) == 0);
            if (idx < src0.size()) x_in = {src1[idx], src0[idx]};
            else x_in = '0;
            #1;
            if (y_out_wr_en) begin
                got0.push_back(y_out[DW-1:0]);
                got1.push_back(y_out[2*DW-1:DW]);
                wr_cyc.push_back(cyc);
            end
            if (x_in_rd_en) begin
                rd_cyc.push_back(cyc);
                idx++;
            end
            cyc++;
        end
        @(negedge clock);
        x_in_empty = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset      = 1'b1;
        x_in_empty = 1'b0;
        y_out_full = 1'b0;
        x_in       = {32'sd77, 32'sd55};
        @(negedge clock);
        @(negedge clock);
        n_checks++;
        if (y_out !== '0) begin
            n_fail++;
            $display("FAIL reset_y_out: got %h, want 0", y_out);
        end
        n_checks++;
        if (x_in_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rd_en: got %b, want 0", x_in_rd_en);
        end
        n_checks++;
        if (y_out_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wr_en: got %b, want 0", y_out_wr_en);
        end
        x_in_empty = 1'b1;
        reset      = 1'b0;
        @(negedge clock);
        n_checks++;
        if (x_in_rd_en !== 1'b0 || y_out_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_empty: got rd=%b wr=%b, want rd=0 wr=0", x_in_rd_en, y_out_wr_en);
        end
        x_in_empty = 1'b0;
        #1;
        n_checks++;
        if (x_in_rd_en !== 1'b1) begin
            n_fail++;
            $display("FAIL load_rd_en: got %b, want 1", x_in_rd_en);
        end
        do_reset();
    endtask

    task automatic test_impulse(input bit starve);
        int exp0 [5] = '{-13, 579, 21, -3, 0};
        do_reset();
        load_impulse(40);
        run(5, starve, starve ? 2000 : 400);
        n_checks++;
        if (got0.size() != 5) begin
            n_fail++;
            $display("FAIL impulse_count(starve=%0d): got %0d outputs, want 5", starve, got0.size());
        end
        for (int i = 0; i < got0.size(); i++) begin
            n_checks++;
            if (got0[i] !== exp0[i]) begin
                n_fail++;
                $display("FAIL impulse_ch0[%0d](starve=%0d): got %0d, want %0d",
                         i, starve, got0[i], exp0[i]);
            end
            n_checks++;
            if (got1[i] !== 32'sd0) begin
                n_fail++;
                $display("FAIL impulse_ch1[%0d]: got %0d, want 0", i, got1[i]);
            end
            if (!starve && rd_cyc.size() > 8 * i + 7) begin
                n_checks++;
                if (wr_cyc[i] != rd_cyc[8*i+7] + TAPS + 1) begin
                    n_fail++;
                    $display("FAIL filter_latency[%0d]: got write at %0d, want %0d",
                             i, wr_cyc[i], rd_cyc[8*i+7] + TAPS + 1);
                end
            end
        end
    endtask

    task automatic test_channels();
        int exp0 [4] = '{-42, 3316, 6674, 6632};
        do_reset();
        src0.delete();
        src1.delete();
        for (int i = 0; i < 32; i++) begin
            src0.push_back(32'sd1024);
            src1.push_back(-32'sd1024);
        end
        run(4, 1'b0, 400);
        n_checks++;
        if (got0.size() != 4) begin
            n_fail++;
            $display("FAIL channels_count: got %0d outputs, want 4", got0.size());
        end
        for (int i = 0; i < got0.size(); i++) begin
            n_checks++;
            if (got0[i] !== exp0[i] || got1[i] !== -exp0[i]) begin
                n_fail++;
                $display("FAIL channels[%0d]: got ch0=%0d ch1=%0d, want ch0=%0d ch1=%0d",
                         i, got0[i], got1[i], exp0[i], -exp0[i]);
            end
        end
    endtask

    task automatic test_bypass();
        do_reset();
        bypass = 1'b1;
        src0.delete();
        src1.delete();
        for (int i = 1; i <= 24; i++) begin
            src0.push_back(32'(i));
            src1.push_back(32'(100 + i));
        end
        run(3, 1'b0, 200);
        n_checks++;
        if (got0.size() != 3) begin
            n_fail++;
            $display("FAIL bypass_count: got %0d outputs, want 3", got0.size());
        end
        for (int i = 0; i < got0.size(); i++) begin
            n_checks++;
            if (got0[i] !== 32'(8 * (i + 1)) || got1[i] !== 32'(108 + 8 * i)) begin
                n_fail++;
                $display("FAIL bypass[%0d]: got ch0=%0d ch1=%0d, want ch0=%0d ch1=%0d",
                         i, got0[i], got1[i], 8 * (i + 1), 108 + 8 * i);
            end
            n_checks++;
            if (wr_cyc[i] != rd_cyc[8*i+7] + 1) begin
                n_fail++;
                $display("FAIL bypass_latency[%0d]: got write at %0d, want %0d",
                         i, wr_cyc[i], rd_cyc[8*i+7] + 1);
            end
        end
        bypass = 1'b0;
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int wr_seen = 0;
        int bad_rd = 0;
        int bad_wr = 0;
        int bad_y = 0;
        logic [CH*DW-1:0] held;
        do_reset();
        load_impulse(24);
        y_out_full = 1'b1;
        for (int c = 0; c < DEC + TAPS + 4; c++) begin
            @(negedge clock);
            x_in_empty = 1'b0;
            x_in = {src1[idx], src0[idx]};
            #1;
            if (x_in_rd_en) idx++;
            if (y_out_wr_en) wr_seen++;
        end
        n_checks++;
        if (idx != DEC || wr_seen != 0) begin
            n_fail++;
            $display("FAIL bp_setup: got reads=%0d writes=%0d, want reads=%0d writes=0",
                     idx, wr_seen, DEC);
        end
        held = y_out;
        n_checks++;
        if (held[DW-1:0] !== -32'sd13) begin
            n_fail++;
            $display("FAIL bp_value: got %0d, want -13", $signed(held[DW-1:0]));
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            x_in = {src1[idx], src0[idx]};
            #1;
            if (x_in_rd_en !== 1'b0) bad_rd++;
            if (y_out_wr_en !== 1'b0) bad_wr++;
            if (y_out !== held) bad_y++;
        end
        n_checks++;
        if (bad_rd != 0 || bad_wr != 0 || bad_y != 0) begin
            n_fail++;
            $display("FAIL bp_hold: got rd_cycles=%0d wr_cycles=%0d y_changes=%0d, want 0 0 0",
                     bad_rd, bad_wr, bad_y);
        end
        @(negedge clock);
        y_out_full = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (y_out_wr_en) wr_seen++;
            @(negedge clock);
        end
        n_checks++;
        if (wr_seen != 1) begin
            n_fail++;
            $display("FAIL bp_release: got %0d writes, want 1", wr_seen);
        end
        x_in_empty = 1'b1;
    endtask

    task automatic test_mid_mac_reset();
        int idx = 0;
        int cyc = 0;
        int last_rd = -1;
        int wr_seen = 0;
        do_reset();
        load_impulse(16);
        // Frame 1 writes -13; reset lands at tap 10 of frame 2.
        while (cyc < 300) begin
            @(negedge clock);
            if (last_rd >= 0 && cyc == last_rd + 11) break;
            x_in_empty = (idx >= src0.size());
            if (idx < src0.size()) x_in = {src1[idx], src0[idx]};
            else x_in = '0;
            #1;
            if (y_out_wr_en) wr_seen++;
            if (x_in_rd_en) begin
                idx++;
                if (idx == 16) last_rd = cyc;
            end
            cyc++;
        end
        n_checks++;
        if (wr_seen != 1 || y_out[DW-1:0] !== -32'sd13) begin
            n_fail++;
            $display("FAIL mid_reset_setup: got writes=%0d y=%0d, want writes=1 y=-13",
                     wr_seen, $signed(y_out[DW-1:0]));
        end
        reset      = 1'b1;
        x_in_empty = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_checks++;
        if (y_out !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_y_out: got %h, want 0", y_out);
        end
        wr_seen = 0;
        for (int c = 0; c < TAPS + 4; c++) begin
            #1;
            if (y_out_wr_en) wr_seen++;
            @(negedge clock);
        end
        n_checks++;
        if (wr_seen != 0) begin
            n_fail++;
            $display("FAIL mid_reset_no_write: got %0d writes, want 0", wr_seen);
        end
        load_impulse(16);
        run(2, 1'b0, 200);
        n_checks++;
        if (got0.size() != 2) begin
            n_fail++;
            $display("FAIL mid_reset_count: got %0d outputs, want 2", got0.size());
        end else begin
            n_checks++;
            if (got0[0] !== -32'sd13 || got0[1] !== 32'sd579) begin
                n_fail++;
                $display("FAIL mid_reset_golden: got %0d,%0d, want -13,579", got0[0], got0[1]);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        x_in       = '0;
        x_in_empty = 1'b1;
        bypass     = 1'b0;
        y_out_full = 1'b0;
        test_reset();
        test_impulse(1'b0);
        test_channels();
        test_bypass();
        test_backpressure();
        test_impulse(1'b1);
        test_mid_mac_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
